// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM stage: opcode map, datapath widths and FSM states.
package pipe_pkg;
  localparam int RD_W   = 7;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 5'd0,
    OP_ALU1  = 5'd1,
    OP_ALU2  = 5'd2,
    OP_ALU3  = 5'd3,
    OP_ALU4  = 5'd4,
    OP_ALU5  = 5'd5,
    OP_CP    = 5'd6,
    OP_B     = 5'd7,
    OP_BEG   = 5'd8,
    OP_ALU9  = 5'd9,
    OP_GP    = 5'd10
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_LOAD_WB  = 2'd2
  } state_e;

  function automatic logic is_wb_op(input logic [OP_W-1:0] op);
    return ((op >= OP_ALU1) && (op <= OP_ALU5)) || (op == OP_ALU9);
  endfunction

  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op > OP_GP;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles with run=1; expired is high during the TIMEOUT_CYC-th such cycle.
// Counter clears combinationally-next whenever run drops, so each wait starts from zero.
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run ? (cnt_q + CNT_W'(1)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/exmem_stage.sv
// EX/MEM stage: one-cycle write-back/branch pulses, blocking memory ops with timeout.
// in_ready is low outside IDLE; an instruction arriving while flush is high is dropped.
module exmem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [RD_W-1:0]   in_branch,
  input  logic [DATA_W-1:0] in_alu,
  output logic              in_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [RD_W-1:0]   br_target,
  output logic              flush,
  output logic [1:0]        err
);
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [RD_W-1:0]   ld_rd_q, ld_rd_d;
  logic              wb_en_q, wb_en_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              br_taken_q, br_taken_d;
  logic [RD_W-1:0]   br_target_q, br_target_d;
  logic              flush_q, flush_d;
  logic [1:0]        err_q, err_d;
  logic              accept;
  logic              expired;

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == ST_MEM_WAIT),
    .expired (expired)
  );

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready && !flush_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_rd_d     = ld_rd_q;
    err_d       = err_q;
    wb_en_d     = 1'b0;
    wb_rd_d     = '0;
    wb_data_d   = '0;
    br_taken_d  = 1'b0;
    br_target_d = '0;
    flush_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_illegal_op(in_opcode)) begin
            err_d[0] = 1'b1;
          end else if (is_wb_op(in_opcode)) begin
            if (in_rd != '0) begin
              wb_en_d   = 1'b1;
              wb_rd_d   = in_rd;
              wb_data_d = in_alu;
            end
          end else if ((in_opcode == OP_B) || ((in_opcode == OP_BEG) && in_alu[0])) begin
            br_taken_d  = 1'b1;
            br_target_d = in_branch;
            flush_d     = 1'b1;
          end else if (in_opcode == OP_CP) begin
            state_d     = ST_MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {{(DATA_W-RD_W){1'b0}}, in_rd};
            mem_wdata_d = in_alu;
          end else if (in_opcode == OP_GP) begin
            state_d     = ST_MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = in_alu;
            mem_wdata_d = '0;
            ld_rd_d     = in_rd;
          end
        end
      end
      ST_MEM_WAIT: begin
        // An ack landing in the expiry cycle still completes the access.
        if (mem_ack || expired) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = ST_IDLE;
          if (!mem_ack) begin
            err_d[1] = 1'b1;
          end else if (!mem_we_q) begin
            state_d = ST_LOAD_WB;
            if (ld_rd_q != '0) begin
              wb_en_d   = 1'b1;
              wb_rd_d   = ld_rd_q;
              wb_data_d = mem_rdata;
            end
          end
        end
      end
      ST_LOAD_WB: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_rd_q     <= '0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      flush_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_rd_q     <= ld_rd_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign flush     = flush_q;
  assign err       = err_q;
endmodule

// File: doc/exmem_stage.md
EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum MEM_WAIT cycles before abort.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL provide port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: ALU result present.
REQ-006 SHALL provide port in_opcode, input, 5 bits: ALU OpCode output.
REQ-007 SHALL provide port in_rd, input, 7 bits: ALU RdOut.
REQ-008 SHALL provide port in_branch, input, 7 bits: ALU branchResult.
REQ-009 SHALL provide port in_alu, input, 32 bits: ALU AluResult.
REQ-010 SHALL provide port in_ready, output, 1 bit: stage can accept.
REQ-011 SHALL provide memory-request ports: mem_req, output, 1 bit; mem_we, output, 1 bit; mem_addr, output, 32 bits; mem_wdata, output, 32 bits.
REQ-012 SHALL provide memory-response ports: mem_ack, input, 1 bit; mem_rdata, input, 32 bits.
REQ-013 SHALL provide write-back ports: wb_en, output, 1 bit; wb_rd, output, 7 bits; wb_data, output, 32 bits.
REQ-014 SHALL provide branch ports: br_taken, output, 1 bit; br_target, output, 7 bits; flush, output, 1 bit.
REQ-015 SHALL provide port err, output, 2 bits, sticky: bit0 = illegal opcode, bit1 = memory timeout.

Function
REQ-016 SHALL accept an input when in_valid && in_ready at a rising edge; in_ready = (state==IDLE) && !rst.
REQ-017 SHALL implement FSM states IDLE, MEM_WAIT, LOAD_WB; IDLE->MEM_WAIT on accepting opcode 6 or 10; MEM_WAIT->LOAD_WB on mem_ack for opcode 10; MEM_WAIT->IDLE on mem_ack for opcode 6; LOAD_WB->IDLE after one cycle.
REQ-018 Opcode 0 (NOP): SHALL produce no output activity.
REQ-019 Opcodes 1-5 and 9: SHALL pulse wb_en for one cycle, the cycle after acceptance, with wb_rd=in_rd and wb_data=in_alu.
REQ-020 SHALL suppress wb_en whenever the destination rd equals 0.
REQ-021 Opcode 7 (B): SHALL pulse br_taken and flush for one cycle, the cycle after acceptance, with br_target=in_branch.
REQ-022 Opcode 8 (BEG): SHALL behave as opcode 7 iff in_alu[0]==1; otherwise no output activity.
REQ-023 SHALL discard an input presented during a cycle in which flush=1, as a wrong-path instruction.
REQ-024 Opcode 6 (CP): SHALL hold mem_req=1, mem_we=1, mem_addr={25'b0,in_rd}, mem_wdata=in_alu from the cycle after acceptance until mem_ack, with no write-back.
REQ-025 Opcode 10 (GP): SHALL hold mem_req=1, mem_we=0, mem_addr=in_alu until mem_ack.
REQ-026 Opcode 10: SHALL capture mem_rdata on mem_ack and drive wb_en=1, wb_rd=in_rd, wb_data=captured data in LOAD_WB.
REQ-027 SHALL keep mem_addr, mem_wdata and mem_we stable while mem_req=1, and drop mem_req the cycle after mem_ack.
REQ-028 SHALL ignore mem_ack outside MEM_WAIT.
REQ-029 SHALL count cycles in MEM_WAIT; at TIMEOUT_CYC cycles without ack it SHALL drop mem_req, set err[1], return to IDLE, and skip write-back.
REQ-030 SHALL give mem_ack priority over timeout when both occur in the same cycle.
REQ-031 Opcodes 11-31: SHALL set err[0] and otherwise behave as NOP.

Reset
REQ-032 While rst=1 the stage SHALL hold state=IDLE, in_ready=0, all outputs 0 (including err and the timeout counter).
REQ-033 Reset asserted in MEM_WAIT or LOAD_WB SHALL drop mem_req and suppress any pending write-back at the next edge.

Structure
REQ-034 Package pipe_pkg SHALL hold the opcode enum (values 0-10), RD_W=7, DATA_W=32, OP_W=5, and the FSM state enum.
REQ-035 The timeout counter SHALL be a sub-module mem_wait_timer (inputs clk, rst, run; output expired).

Verification
REQ-036 ALU op: accept opcode 5, rd=3, alu=0x0000_0010 -> next cycle wb_en=1, wb_rd=3, wb_data=0x10, for exactly one cycle.
REQ-037 Branch: accept opcode 8, alu=1, branch=0x2A -> next cycle br_taken=1, br_target=0x2A, flush=1; an in_valid in that cycle is dropped; repeat with alu=0 -> no outputs.
REQ-038 Load: accept opcode 10, rd=9, alu=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_req high for 3 cycles, addr 0x100, then wb_rd=9, wb_data=0xDEADBEEF; in_ready=0 throughout.
REQ-039 Timeout: TIMEOUT_CYC=4, opcode 6 with no ack -> mem_req drops after 4 cycles, err=2'b10, no wb_en; ack together with the 4th cycle -> completes normally with err=0.
REQ-040 Reset mid-load: rst asserted in MEM_WAIT -> next edge mem_req=0, no wb_en, err=0, in_ready=1 the cycle after rst deasserts.
